// File: rtl/mem_writeback.sv
// Memory-access + writeback stage: runs loads/stores over a req/ack handshake,
// formats load data and drives the registered register-bank write port.
module mem_writeback (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_con_Mmemread,
  input  logic        i_con_Mmemwrite,
  input  logic [1:0]  i_con_Wloadmux,
  input  logic        i_con_Walupc8,
  input  logic        i_con_Wmemtoreg,
  input  logic        i_con_Wregwrite,
  input  logic [4:0]  i_addr_Wreg,
  input  logic [31:0] i_data_alu,
  input  logic [31:0] i_data_rt,
  input  logic [31:0] i_addr_pc4,
  output logic        o_con_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_addr_mem,
  output logic [31:0] o_data_memw,
  input  logic        i_mem_ack,
  input  logic [31:0] i_data_memr,
  output logic        o_con_Wregwrite,
  output logic [4:0]  o_addr_Wregwrite,
  output logic [31:0] o_data_Wregwrite,
  output logic        o_con_misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q;
  logic [1:0]  size_q, off_q;
  logic        alupc8_q, memtoreg_q, regwrite_q;
  logic [4:0]  dest_q;
  logic [31:0] alu_q, pc4_q;
  logic        req_q, we_q;
  logic [3:0]  be_q;
  logic [31:0] maddr_q, mwdata_q;
  logic        wr_q, mis_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        memop, misalign, accept;
  logic [3:0]  be_d;
  logic [31:0] mwdata_d;

  // Big-endian lanes: offset 0 is the most significant byte/half.
  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] sz,
                                           input logic [1:0] off);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? d[15:0] : d[31:16];
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    case (sz)
      2'b00:   fmt_load = d;
      2'b01:   fmt_load = {{16{h[15]}}, h};
      2'b10:   fmt_load = {{24{b[7]}}, b};
      default: fmt_load = {24'd0, b};
    endcase
  endfunction

  function automatic logic [31:0] wb_sel(input logic lnk, input logic m2r, input logic [31:0] pc4,
                                         input logic [31:0] ld, input logic [31:0] alu);
    if (lnk)      wb_sel = pc4 + 32'd4;
    else if (m2r) wb_sel = ld;
    else          wb_sel = alu;
  endfunction

  assign memop = i_con_Mmemread | i_con_Mmemwrite;

  always_comb begin
    misalign = 1'b0;
    case (i_con_Wloadmux)
      2'b00:   misalign = memop && (i_data_alu[1:0] != 2'b00);
      2'b01:   misalign = memop && i_data_alu[0];
      default: misalign = 1'b0;
    endcase
  end

  assign accept      = (state_q == S_IDLE) && i_valid && memop && !misalign;
  assign o_con_stall = accept || ((state_q == S_WAIT) && !i_mem_ack);

  always_comb begin
    be_d     = 4'b1111;
    mwdata_d = i_data_rt;
    case (i_con_Wloadmux)
      2'b00: begin
        be_d     = 4'b1111;
        mwdata_d = i_data_rt;
      end
      2'b01: begin
        be_d     = i_data_alu[1] ? 4'b0011 : 4'b1100;
        mwdata_d = {2{i_data_rt[15:0]}};
      end
      default: begin
        be_d     = 4'b1000 >> i_data_alu[1:0];
        mwdata_d = {4{i_data_rt[7:0]}};
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      off_q      <= '0;
      alupc8_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      dest_q     <= '0;
      alu_q      <= '0;
      pc4_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      wr_q  <= 1'b0;
      mis_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            if (!memop) begin
              wr_q    <= i_con_Wregwrite && (i_addr_Wreg != 5'd0);
              waddr_q <= i_addr_Wreg;
              wdata_q <= wb_sel(i_con_Walupc8, i_con_Wmemtoreg, i_addr_pc4,
                                fmt_load(i_data_memr, i_con_Wloadmux, i_data_alu[1:0]),
                                i_data_alu);
            end else if (misalign) begin
              mis_q <= 1'b1;
            end else begin
              size_q     <= i_con_Wloadmux;
              off_q      <= i_data_alu[1:0];
              alupc8_q   <= i_con_Walupc8;
              memtoreg_q <= i_con_Wmemtoreg;
              regwrite_q <= i_con_Wregwrite;
              dest_q     <= i_addr_Wreg;
              alu_q      <= i_data_alu;
              pc4_q      <= i_addr_pc4;
              req_q      <= 1'b1;
              we_q       <= i_con_Mmemwrite;
              be_q       <= be_d;
              maddr_q    <= {i_data_alu[31:2], 2'b00};
              mwdata_q   <= mwdata_d;
              state_q    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_mem_ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wr_q    <= regwrite_q && (dest_q != 5'd0);
            waddr_q <= dest_q;
            wdata_q <= wb_sel(alupc8_q, memtoreg_q, pc4_q,
                              fmt_load(i_data_memr, size_q, off_q), alu_q);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req        = req_q;
  assign o_mem_we         = we_q;
  assign o_mem_be         = be_q;
  assign o_addr_mem       = maddr_q;
  assign o_data_memw      = mwdata_q;
  assign o_con_Wregwrite  = wr_q;
  assign o_addr_Wregwrite = waddr_q;
  assign o_data_Wregwrite = wdata_q;
  assign o_con_misalign   = mis_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Randomized bench for mem_writeback: expected outputs are scheduled per cycle
// from each instruction's transaction-level behaviour and compared every cycle.
module tb_mem_writeback;
  localparam int NC = 8192;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_con_Mmemread, i_con_Mmemwrite;
  logic [1:0]  i_con_Wloadmux;
  logic        i_con_Walupc8, i_con_Wmemtoreg, i_con_Wregwrite;
  logic [4:0]  i_addr_Wreg;
  logic [31:0] i_data_alu, i_data_rt, i_addr_pc4;
  logic        o_con_stall, o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_addr_mem, o_data_memw;
  logic        i_mem_ack;
  logic [31:0] i_data_memr;
  logic        o_con_Wregwrite;
  logic [4:0]  o_addr_Wregwrite;
  logic [31:0] o_data_Wregwrite;
  logic        o_con_misalign;

  mem_writeback dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_con_Mmemread(i_con_Mmemread), .i_con_Mmemwrite(i_con_Mmemwrite),
    .i_con_Wloadmux(i_con_Wloadmux), .i_con_Walupc8(i_con_Walupc8),
    .i_con_Wmemtoreg(i_con_Wmemtoreg), .i_con_Wregwrite(i_con_Wregwrite),
    .i_addr_Wreg(i_addr_Wreg), .i_data_alu(i_data_alu), .i_data_rt(i_data_rt),
    .i_addr_pc4(i_addr_pc4), .o_con_stall(o_con_stall), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_addr_mem(o_addr_mem),
    .o_data_memw(o_data_memw), .i_mem_ack(i_mem_ack), .i_data_memr(i_data_memr),
    .o_con_Wregwrite(o_con_Wregwrite), .o_addr_Wregwrite(o_addr_Wregwrite),
    .o_data_Wregwrite(o_data_Wregwrite), .o_con_misalign(o_con_misalign)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit          e_stall [NC];
  bit          e_req   [NC];
  bit          e_we    [NC];
  bit          e_wr    [NC];
  bit          e_mis   [NC];
  logic [3:0]  e_be    [NC];
  logic [31:0] e_maddr [NC];
  logic [31:0] e_mwd   [NC];
  logic [4:0]  e_addr  [NC];
  logic [31:0] e_data  [NC];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en && cyc < NC) begin
      chk("stall", o_con_stall, e_stall[cyc]);
      chk("mem_req", o_mem_req, e_req[cyc]);
      if (e_req[cyc]) begin
        chk("mem_we", o_mem_we, e_we[cyc]);
        chk("mem_be", o_mem_be, e_be[cyc]);
        chk("mem_addr", o_addr_mem, e_maddr[cyc]);
        if (e_we[cyc]) chk("mem_wdata", o_data_memw, e_mwd[cyc]);
      end
      chk("wr_en", o_con_Wregwrite, e_wr[cyc]);
      if (e_wr[cyc]) begin
        chk("wr_addr", o_addr_Wregwrite, e_addr[cyc]);
        chk("wr_data", o_data_Wregwrite, e_data[cyc]);
      end
      chk("misalign", o_con_misalign, e_mis[cyc]);
    end
  end

  // Load result from plain shifts and masks on the big-endian word.
  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] sz,
                                      input logic [1:0] off);
    int unsigned v;
    int unsigned sh;
    if (sz == 2'b00) return d;
    if (sz == 2'b01) begin
      sh = off[1] ? 0 : 16;
      v  = (d >> sh) & 32'hFFFF;
      if (v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    sh = 8 * (3 - int'(off));
    v  = (d >> sh) & 32'hFF;
    if (sz == 2'b10 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'hF;
    if (sz == 2'b01) return off[1] ? 4'h3 : 4'hC;
    return 4'b1000 >> off;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] rt);
    if (sz == 2'b00) return rt;
    if (sz == 2'b01) return (rt & 32'hFFFF) * 32'h0001_0001;
    return (rt & 32'hFF) * 32'h0101_0101;
  endfunction

  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_valid         = 1'b0;
      i_con_Mmemread  = 1'($urandom);
      i_con_Mmemwrite = 1'($urandom);
      i_con_Wregwrite = 1'($urandom);
      i_data_alu      = $urandom;
      i_mem_ack       = 1'($urandom);
      i_data_memr     = $urandom;
      next_cyc();
    end
  endtask

  task automatic run_instr(input bit mr, input bit mw, input bit [1:0] sz, input bit lnk,
                           input bit m2r, input bit rw, input bit [4:0] dst,
                           input bit [31:0] alu, input bit [31:0] rt, input bit [31:0] pc4,
                           input int k, input bit [31:0] memr);
    int n;
    bit memop, mis;
    n = int'(cyc);
    i_valid = 1'b1;
    i_con_Mmemread = mr;  i_con_Mmemwrite = mw;  i_con_Wloadmux = sz;
    i_con_Walupc8 = lnk;  i_con_Wmemtoreg = m2r; i_con_Wregwrite = rw;
    i_addr_Wreg = dst;    i_data_alu = alu;      i_data_rt = rt;  i_addr_pc4 = pc4;
    i_mem_ack = 1'($urandom);
    i_data_memr = $urandom;
    memop = mr | mw;
    mis = memop && ((sz == 2'b00 && alu[1:0] != 2'b00) || (sz == 2'b01 && alu[0]));
    if (!memop) begin
      e_wr[n+1]   = rw && dst != 0;
      e_addr[n+1] = dst;
      e_data[n+1] = lnk ? pc4 + 32'd4 : alu;
      next_cyc();
    end else if (mis) begin
      e_mis[n+1] = 1'b1;
      next_cyc();
    end else begin
      for (int j = 0; j < k; j++) e_stall[n+j] = 1'b1;
      for (int j = 1; j <= k; j++) begin
        e_req[n+j]   = 1'b1;
        e_we[n+j]    = mw;
        e_be[n+j]    = exp_be(sz, alu[1:0]);
        e_maddr[n+j] = alu & 32'hFFFF_FFFC;
        e_mwd[n+j]   = exp_wd(sz, rt);
      end
      e_wr[n+k+1]   = rw && dst != 0;
      e_addr[n+k+1] = dst;
      e_data[n+k+1] = lnk ? pc4 + 32'd4 : (m2r ? fmt(memr, sz, alu[1:0]) : alu);
      next_cyc();
      i_mem_ack = 1'b0;
      for (int j = 1; j < k; j++) next_cyc();
      i_mem_ack   = 1'b1;
      i_data_memr = memr;
      next_cyc();
      i_mem_ack   = 1'b0;
      i_data_memr = $urandom;
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n, t, k;
    bit [1:0]  sz;
    bit [4:0]  dst;
    bit [31:0] alu;
    i_rst = 1'b1; i_valid = 1'b0; i_con_Mmemread = 1'b0; i_con_Mmemwrite = 1'b0;
    i_con_Wloadmux = '0; i_con_Walupc8 = 1'b0; i_con_Wmemtoreg = 1'b0;
    i_con_Wregwrite = 1'b0; i_addr_Wreg = '0; i_data_alu = '0; i_data_rt = '0;
    i_addr_pc4 = '0; i_mem_ack = 1'b0; i_data_memr = '0;
    next_cyc();
    chk_en = 1'b1;
    next_cyc();
    i_rst = 1'b0;
    idle(2);

    run_instr(0, 0, 2'b00, 0, 0, 1, 5'd8, 32'h0000_1234, 0, 0, 1, 0);
    chk("alu_lit_en", o_con_Wregwrite, 1);
    chk("alu_lit_data", o_data_Wregwrite, 32'h0000_1234);
    run_instr(1, 0, 2'b10, 0, 1, 1, 5'd5, 32'h0000_0101, 0, 0, 3, 32'h1182_3344);
    chk("lb_lit_data", o_data_Wregwrite, 32'hFFFF_FF82);
    run_instr(0, 1, 2'b01, 0, 0, 0, 5'd0, 32'h0000_0102, 32'h0000_BEEF, 0, 2, 0);
    run_instr(0, 0, 2'b00, 1, 0, 1, 5'd31, 32'h55, 0, 32'h0040_0010, 1, 0);
    chk("link_lit_data", o_data_Wregwrite, 32'h0040_0014);
    run_instr(1, 0, 2'b00, 0, 1, 1, 5'd4, 32'h0000_0202, 0, 0, 1, 0);
    chk("misalign_lit", o_con_misalign, 1);
    chk("misalign_no_wr", o_con_Wregwrite, 0);
    run_instr(0, 0, 2'b00, 0, 0, 1, 5'd0, 32'h77, 0, 0, 1, 0);
    chk("dest0_lit", o_con_Wregwrite, 0);
    idle(1);

    for (int it = 0; it < 400; it++) begin
      t   = int'($urandom % 4);
      sz  = 2'($urandom);
      dst = 5'($urandom);
      alu = $urandom;
      k   = 1 + int'($urandom % 4);
      if ($urandom % 4 != 0) begin
        if (sz == 2'b00) alu[1:0] = 2'b00;
        if (sz == 2'b01) alu[0] = 1'b0;
      end
      case (t)
        0: run_instr(0, 0, sz, 0, 0, 1, dst, alu, $urandom, $urandom, k, $urandom);
        1: run_instr(0, 0, sz, 1, 0, 1, dst, alu, $urandom, $urandom, k, $urandom);
        2: run_instr(1, 0, sz, 0, 1, 1, dst, alu, $urandom, $urandom, k, $urandom);
        default: run_instr(0, 1, sz, 0, 0, 0, dst, alu, $urandom, $urandom, k, $urandom);
      endcase
      idle(int'($urandom % 3));
    end

    // Reset while a load waits for ack: request drops, late ack produces nothing.
    n = int'(cyc);
    i_valid = 1'b1; i_con_Mmemread = 1'b1; i_con_Mmemwrite = 1'b0;
    i_con_Wloadmux = 2'b00; i_con_Walupc8 = 1'b0; i_con_Wmemtoreg = 1'b1;
    i_con_Wregwrite = 1'b1; i_addr_Wreg = 5'd9; i_data_alu = 32'h0000_0300;
    i_mem_ack = 1'b0;
    e_stall[n] = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      e_stall[n+j] = 1'b1;
      e_req[n+j]   = 1'b1;
      e_we[n+j]    = 1'b0;
      e_be[n+j]    = 4'hF;
      e_maddr[n+j] = 32'h0000_0300;
    end
    next_cyc();
    next_cyc();
    i_rst = 1'b1;
    next_cyc();
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_mem_ack = 1'b1;
    i_data_memr = 32'hDEAD_BEEF;
    next_cyc();
    chk("rst_wait_req", o_mem_req, 0);
    i_mem_ack = 1'b0;
    next_cyc();
    chk("rst_wait_no_wr", o_con_Wregwrite, 0);
    idle(3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
